// File: rtl/micro_sequencer_if.sv
// Microword/sequencer bundle: next-address controls in, microaddress and stack status out.
// Latency: none, wiring only.
// Backpressure: none; the sequencer stalls only through the mfc/WAIT mechanism.
interface micro_sequencer_if #(
    parameter int AW    = 6,
    parameter int NCOND = 4,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(NCOND);
    localparam int LW = $clog2(DEPTH + 1);

    logic [2:0]       ns;
    logic [CW-1:0]    csel;
    logic             inv;
    logic [AW-1:0]    target;
    logic [AW-1:0]    entry;
    logic [NCOND-1:0] cond;
    logic             mfc;
    logic [AW-1:0]    uaddr;
    logic             waiting;
    logic [LW-1:0]    level;
    logic             ovf;
    logic             unf;

    modport master (
        output ns, csel, inv, target, entry, cond, mfc,
        input  uaddr, waiting, level, ovf, unf
    );

    modport slave (
        input  ns, csel, inv, target, entry, cond, mfc,
        output uaddr, waiting, level, ovf, unf
    );
endinterface

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: next microaddress from ns mode, condition mux and optional return stack (USEQ_STACK_EN).
// Latency: uaddr updates one clock after ns/inputs are sampled, one microword per cycle.
// Backpressure: ns=WAIT holds uaddr while mfc is low; waiting flags the stall combinationally.
module micro_sequencer #(
    parameter int AW    = 6,
    parameter int NCOND = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             CLR,
    micro_sequencer_if.slave bus
);
    localparam int CW = $clog2(NCOND);
    localparam int LW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        NS_INC   = 3'b000,
        NS_JMP   = 3'b001,
        NS_DISP  = 3'b010,
        NS_FETCH = 3'b011,
        NS_CJMP  = 3'b100,
        NS_CALL  = 3'b101,
        NS_RET   = 3'b110,
        NS_WAIT  = 3'b111
    } ns_t;

    ns_t           mode;
    logic [AW-1:0] uaddr_q;
    logic [AW-1:0] uaddr_d;
    logic [AW-1:0] uaddr_inc;
    logic          c_sel;
    logic          c;

    assign mode      = ns_t'(bus.ns);
    assign uaddr_inc = uaddr_q + AW'(1);  // wraps modulo 2^AW by width

    // Condition mux; a select past the last condition reads as 0 before inversion.
    always_comb begin
        c_sel = 1'b0;
        for (int i = 0; i < NCOND; i++) begin
            if (bus.csel == CW'(i)) c_sel = bus.cond[i];
        end
        c = c_sel ^ bus.inv;
    end

`ifdef USEQ_STACK_EN
    logic [AW-1:0] stack [DEPTH];
    logic [AW-1:0] top;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic          ovf_q;
    logic          ovf_d;
    logic          unf_q;
    logic          unf_d;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);

    // Top-of-stack read: entry at index level-1.
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (level_q == LW'(i + 1)) top = stack[i];
        end
    end

    // Next-address select plus stack push/pop and sticky error flags.
    always_comb begin
        uaddr_d = uaddr_inc;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        level_d = level_q;
        case (mode)
            NS_INC:   uaddr_d = uaddr_inc;
            NS_JMP:   uaddr_d = bus.target;
            NS_DISP:  uaddr_d = bus.entry;
            NS_FETCH: uaddr_d = '0;
            NS_CJMP:  uaddr_d = c ? bus.target : uaddr_inc;
            NS_CALL: begin
                uaddr_d = bus.target;
                if (full) ovf_d = 1'b1;
                else      push  = 1'b1;
            end
            NS_RET: begin
                if (empty) begin
                    uaddr_d = '0;
                    unf_d   = 1'b1;
                end else begin
                    uaddr_d = top;
                    pop     = 1'b1;
                end
            end
            NS_WAIT:  uaddr_d = bus.mfc ? uaddr_inc : uaddr_q;
        endcase
        if (push) level_d = level_q + LW'(1);
        if (pop)  level_d = level_q - LW'(1);
    end

    // Stack storage is deliberately left unreset; only level defines validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && level_q == LW'(i)) stack[i] <= uaddr_inc;
        end
    end

    // Stack occupancy and sticky flags; the flags clear only on CLR.
    always_ff @(posedge clk or negedge CLR) begin
        if (!CLR) begin
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.level = level_q;
    assign bus.ovf   = ovf_q;
    assign bus.unf   = unf_q;
`else
    // Next-address select without a stack: CALL jumps, RET refetches.
    always_comb begin
        uaddr_d = uaddr_inc;
        case (mode)
            NS_INC:   uaddr_d = uaddr_inc;
            NS_JMP:   uaddr_d = bus.target;
            NS_DISP:  uaddr_d = bus.entry;
            NS_FETCH: uaddr_d = '0;
            NS_CJMP:  uaddr_d = c ? bus.target : uaddr_inc;
            NS_CALL:  uaddr_d = bus.target;
            NS_RET:   uaddr_d = '0;
            NS_WAIT:  uaddr_d = bus.mfc ? uaddr_inc : uaddr_q;
        endcase
    end

    assign bus.level = '0;
    assign bus.ovf   = 1'b0;
    assign bus.unf   = 1'b0;
`endif

    // Microaddress register, loaded every cycle.
    always_ff @(posedge clk or negedge CLR) begin
        if (!CLR) uaddr_q <= '0;
        else      uaddr_q <= uaddr_d;
    end

    assign bus.uaddr   = uaddr_q;
    assign bus.waiting = (mode == NS_WAIT) && !bus.mfc;
endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: counting, branches, call/return, WAIT stall and async clear.
// Latency: checks one clock after each microword is applied.
// Backpressure: exercises WAIT with mfc held low then released.
module tb_micro_sequencer;
    localparam int AW    = 6;
    localparam int NCOND = 4;
    localparam int DEPTH = 4;
`ifdef USEQ_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    localparam logic [2:0] INC   = 3'b000;
    localparam logic [2:0] JMP   = 3'b001;
    localparam logic [2:0] DISP  = 3'b010;
    localparam logic [2:0] FETCH = 3'b011;
    localparam logic [2:0] CJMP  = 3'b100;
    localparam logic [2:0] CALL  = 3'b101;
    localparam logic [2:0] RET   = 3'b110;
    localparam logic [2:0] WAIT  = 3'b111;

    logic clk;
    logic CLR;
    int   tests;
    int   fails;

    micro_sequencer_if #(.AW(AW), .NCOND(NCOND), .DEPTH(DEPTH)) bus ();

    micro_sequencer #(.AW(AW), .NCOND(NCOND), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .CLR (CLR),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [2:0] m);
        bus.ns = m;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        CLR        = 1'b0;
        bus.ns     = INC;
        bus.csel   = '0;
        bus.inv    = 1'b0;
        bus.target = '0;
        bus.entry  = '0;
        bus.cond   = '0;
        bus.mfc    = 1'b0;

        // Reset state, observed before any clock edge
        #3;
        chk("rst_uaddr", 32'(bus.uaddr), 0);
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_ovf",   32'(bus.ovf),   0);
        chk("rst_unf",   32'(bus.unf),   0);
        chk("rst_wait",  32'(bus.waiting), 0);
        #9 CLR = 1'b1;

        // INC x64: count 1..63 then wrap to 0, flags stay clear
        for (int k = 0; k < 64; k++) begin
            step(INC);
            chk("inc_uaddr", 32'(bus.uaddr), (k + 1) % 64);
        end
        chk("wrap_ovf", 32'(bus.ovf), 0);
        chk("wrap_unf", 32'(bus.unf), 0);

        // Conditional jump: cond[1]=1 selected
        bus.cond   = 4'b0010;
        bus.csel   = 2'd1;
        bus.target = 6'h20;
        bus.inv    = 1'b0;
        step(CJMP);
        chk("cjmp_taken", 32'(bus.uaddr), 32'h20);
        bus.inv = 1'b1;
        step(CJMP);
        chk("cjmp_inv", 32'(bus.uaddr), 32'h21);
        bus.csel = 2'd0;
        bus.inv  = 1'b0;
        step(CJMP);
        chk("cjmp_c0_fall", 32'(bus.uaddr), 32'h22);
        bus.inv = 1'b1;
        step(CJMP);
        chk("cjmp_c0_inv", 32'(bus.uaddr), 32'h20);

        // Dispatch and fetch
        bus.entry = 6'h2A;
        step(DISP);
        chk("disp", 32'(bus.uaddr), 32'h2A);
        step(FETCH);
        chk("fetch", 32'(bus.uaddr), 0);

        // Single CALL/RET from uaddr 5
        bus.target = 6'h05;
        step(JMP);
        chk("jmp5", 32'(bus.uaddr), 5);
        bus.target = 6'h10;
        step(CALL);
        chk("call_uaddr", 32'(bus.uaddr), 32'h10);
        chk("call_level", 32'(bus.level), STK ? 1 : 0);
        step(RET);
        chk("ret_uaddr", 32'(bus.uaddr), STK ? 6 : 0);
        chk("ret_level", 32'(bus.level), 0);

        // Five nested CALLs into a depth-4 stack
        bus.target = 6'h01;
        step(JMP);
        for (int k = 1; k <= 5; k++) begin
            bus.target = 6'(16 + k);
            step(CALL);
            chk("ncall_uaddr", 32'(bus.uaddr), 16 + k);
            chk("ncall_level", 32'(bus.level), STK ? ((k < 4) ? k : 4) : 0);
            chk("ncall_ovf",   32'(bus.ovf),   (STK && k == 5) ? 1 : 0);
        end
        chk("nret_pre_unf", 32'(bus.unf), 0);
        step(RET);
        chk("nret1_uaddr", 32'(bus.uaddr), STK ? 32'h14 : 0);
        step(RET);
        chk("nret2_uaddr", 32'(bus.uaddr), STK ? 32'h13 : 0);
        step(RET);
        chk("nret3_uaddr", 32'(bus.uaddr), STK ? 32'h12 : 0);
        step(RET);
        chk("nret4_uaddr", 32'(bus.uaddr), STK ? 2 : 0);
        chk("nret4_level", 32'(bus.level), 0);
        step(INC);
        step(RET);
        chk("under_uaddr", 32'(bus.uaddr), 0);
        chk("under_unf",   32'(bus.unf),   STK ? 1 : 0);
        step(INC);
        step(INC);
        chk("sticky_ovf", 32'(bus.ovf), STK ? 1 : 0);
        chk("sticky_unf", 32'(bus.unf), STK ? 1 : 0);

        // WAIT at 9 with mfc low for three cycles
        bus.target = 6'h09;
        step(JMP);
        chk("jmp9", 32'(bus.uaddr), 9);
        bus.mfc = 1'b0;
        bus.ns  = WAIT;
        #1;
        chk("wait_comb", 32'(bus.waiting), 1);
        for (int k = 0; k < 3; k++) begin
            step(WAIT);
            chk("wait_hold", 32'(bus.uaddr), 9);
            chk("wait_flag", 32'(bus.waiting), 1);
        end
        bus.mfc = 1'b1;
        #1;
        chk("wait_release_comb", 32'(bus.waiting), 0);
        step(WAIT);
        chk("wait_done", 32'(bus.uaddr), 10);

        // Async clear mid-WAIT with two frames on the stack
        bus.target = 6'h30;
        step(CALL);
        bus.target = 6'h31;
        step(CALL);
        chk("pre_clr_level", 32'(bus.level), STK ? 2 : 0);
        bus.mfc = 1'b0;
        step(WAIT);
        chk("pre_clr_uaddr", 32'(bus.uaddr), 32'h31);
        #2 CLR = 1'b0;
        #1;
        chk("clr_uaddr", 32'(bus.uaddr), 0);
        chk("clr_level", 32'(bus.level), 0);
        chk("clr_ovf",   32'(bus.ovf),   0);
        chk("clr_unf",   32'(bus.unf),   0);
        #2 CLR = 1'b1;
        bus.ns = INC;
        step(INC);
        chk("post_clr_inc", 32'(bus.uaddr), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 Parameter AW, default 6: microaddress width.
REQ-002 Parameter NCOND, default 4, minimum 2: number of condition inputs.
REQ-003 Parameter DEPTH, default 4, minimum 1: return-stack depth.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 CLR  input  1  reset, asynchronous, active-low.
REQ-006 ns  input  3  next-address mode field from the current microword.
REQ-007 csel  input  clog2(NCOND)  condition select.
REQ-008 inv  input  1  condition invert.
REQ-009 target  input  AW  branch/call target from the microword.
REQ-010 entry  input  AW  dispatch address from the instruction encoder.
REQ-011 cond  input  NCOND  condition vector; bit 0 is the ARM condition-evaluator result.
REQ-012 mfc  input  1  memory-function-complete.
REQ-013 uaddr  output  AW  current microaddress, registered.
REQ-014 waiting  output  1  combinational; high when ns=WAIT and mfc=0.
REQ-015 level  output  clog2(DEPTH+1)  stack occupancy.
REQ-016 ovf  output  1  sticky stack-overflow flag.
REQ-017 unf  output  1  sticky stack-underflow flag.

Function
REQ-018 Evaluate the selected condition as c = cond[csel] XOR inv; csel >= NCOND SHALL yield c = 0 before inversion.
REQ-019 Compute next address each cycle by ns, with uaddr loading it on every rising edge: 000 INC uaddr+1; 001 JMP target; 010 DISP entry; 011 FETCH 0; 100 CJMP target if c else uaddr+1; 101 CALL; 110 RET; 111 WAIT.
REQ-020 uaddr+1 SHALL wrap modulo 2^AW: all-ones goes to 0 with no flag.
REQ-021 CALL, level<DEPTH: push uaddr+1, increment level, jump to target, all in one cycle.
REQ-022 CALL, level==DEPTH: no push, level unchanged, set ovf, jump to target.
REQ-023 RET, level>0: load the top entry, decrement level.
REQ-024 RET, level==0: set unf, load 0.
REQ-025 WAIT: hold uaddr while mfc=0; load uaddr+1 in the cycle mfc=1 is sampled.
REQ-026 Latency: the new uaddr is visible one clock after the ns/inputs are sampled; no bubbles.
REQ-027 Stack SHALL be LIFO; entries beyond level are don't-care.
REQ-028 ovf and unf SHALL clear only on CLR.

Reset
REQ-029 CLR low SHALL immediately force uaddr=0, level=0, ovf=0, unf=0, regardless of clk, including mid-WAIT or mid-CALL.
REQ-030 Stack contents are not reset.
REQ-031 The first rising edge with CLR high SHALL act on the current ns normally.

Configuration
REQ-032 Macro USEQ_STACK_EN SHALL control the return stack.
REQ-033 With USEQ_STACK_EN defined, the stack SHALL be built per REQ-021..REQ-024.
REQ-034 Without USEQ_STACK_EN, no stack storage SHALL exist, with:
- CALL behaving as JMP;
- RET behaving as FETCH;
- level, ovf and unf tied to 0.

Verification
REQ-035 Reset then INC x64, AW=6 -> uaddr counts 0..63, then 0 with no flags.
REQ-036 CJMP with target=0x20, cond[1]=1, csel=1: inv=0 -> uaddr 0x20; inv=1 -> uaddr+1.
REQ-037 From uaddr 5, CALL target 0x10, then RET -> uaddr 0x10, level 1, then uaddr 6, level 0.
REQ-038 DEPTH=4: five nested CALLs -> level 4, ovf=1, fifth jump taken; RET at level 0 -> uaddr 0, unf=1.
REQ-039 WAIT at uaddr 9, mfc low for 3 cycles then high -> uaddr 9 held for 3 cycles with waiting=1, then uaddr 10.
REQ-040 CLR asserted between edges during WAIT with level=2 -> uaddr 0, level 0 immediately; rerun REQ-037 without USEQ_STACK_EN -> RET gives uaddr 0.
